// File: rtl/track_pkg.sv
// Shared types for the multi-track playback controller: per-track state encoding
// and the upper bound on the track count.
package track_pkg;

  typedef enum logic [1:0] {
    STOPPED       = 2'd0,
    PENDING_START = 2'd1,
    PLAYING       = 2'd2,
    PENDING_STOP  = 2'd3
  } track_state_t;

  localparam int MAX_TRACKS = 16;

endpackage

// File: rtl/track_slot.sv
// One playback track: play toggling, optionally quantised to the beat pulse,
// with a global stop that overrides everything else.
module track_slot
  import track_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         play,
  input  logic         beat,
  input  logic         stop_all,
  input  logic         quantise,
  output track_state_t state,
  output logic         playing,
  output logic         pending
);

  track_state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= STOPPED;
    else     state <= next_state;
  end

  // A play that coincides with a beat resolves in the same edge; a cancel beats the beat.
  always_comb begin
    next_state = state;
    if (stop_all) begin
      next_state = STOPPED;
    end else if (!quantise) begin
      if (play) next_state = playing ? STOPPED : PLAYING;
    end else begin
      unique case (state)
        STOPPED:       if (play) next_state = beat ? PLAYING : PENDING_START;
        PENDING_START: if (play) next_state = STOPPED; else if (beat) next_state = PLAYING;
        PLAYING:       if (play) next_state = beat ? STOPPED : PENDING_STOP;
        PENDING_STOP:  if (play) next_state = PLAYING; else if (beat) next_state = STOPPED;
        default:       next_state = STOPPED;
      endcase
    end
  end

  assign playing = (state == PLAYING) || (state == PENDING_STOP);
  assign pending = (state == PENDING_START) || (state == PENDING_STOP);

endmodule

// File: rtl/multi_track_controller.sv
// Track selection pointer, play demux and mixer-enable mask over NUM_TRACKS track slots.
// Optional solo of the selected track is enabled by defining MULTI_TRACK_SOLO_EN.
module multi_track_controller
  import track_pkg::*;
#(
  parameter  int NUM_TRACKS = 4,
  parameter  int QUANTISE   = 1,
  localparam int SEL_W      = $clog2(NUM_TRACKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cycle_sig,
  input  logic                  cycle_back_sig,
  input  logic                  play_sig,
  input  logic                  stop_all_sig,
  input  logic                  beat_sig,
  input  logic                  solo_sig,
  output logic [SEL_W-1:0]      current_track,
  output logic [NUM_TRACKS-1:0] tracks_playing,
  output logic [NUM_TRACKS-1:0] tracks_pending,
  output logic [NUM_TRACKS-1:0] tracks_audible
);

  if (NUM_TRACKS < 2 || NUM_TRACKS > MAX_TRACKS) begin : g_bad_count
    $error("multi_track_controller: NUM_TRACKS out of range");
  end

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_TRACKS - 1);

  logic [NUM_TRACKS-1:0] play_vec;
  track_state_t          state_unused [NUM_TRACKS];

  // Explicit wrap keeps the pointer below NUM_TRACKS for non-power-of-2 counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      current_track <= '0;
    end else if (cycle_sig && !cycle_back_sig) begin
      current_track <= (current_track == LAST) ? '0 : current_track + 1'b1;
    end else if (cycle_back_sig && !cycle_sig) begin
      current_track <= (current_track == '0) ? LAST : current_track - 1'b1;
    end
  end

  // Decoded from the pre-update pointer, so play lands on the track selected this cycle.
  always_comb begin
    play_vec = '0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      play_vec[i] = play_sig && (current_track == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_slot
    track_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .play     (play_vec[g]),
      .beat     (beat_sig),
      .stop_all (stop_all_sig),
      .quantise (QUANTISE != 0),
      .state    (state_unused[g]),
      .playing  (tracks_playing[g]),
      .pending  (tracks_pending[g])
    );
  end

`ifdef MULTI_TRACK_SOLO_EN
  logic solo_q;

  always_ff @(posedge clk) begin
    if (rst) solo_q <= 1'b0;
    else     solo_q <= solo_sig;
  end

  // Mask follows the live pointer, so reselecting while soloed moves the solo.
  always_comb begin
    tracks_audible = tracks_playing;
    if (solo_q) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        if (current_track != SEL_W'(i)) tracks_audible[i] = 1'b0;
      end
    end
  end
`else
  logic solo_unused;

  assign solo_unused    = solo_sig;
  assign tracks_audible = tracks_playing;
`endif

endmodule

// File: tb/tb_multi_track_controller.sv
// Bench for multi_track_controller: three instances (4/Q1, 3/Q1, 4/Q0) on shared stimulus,
// directed scenarios plus random traffic against a want/on behavioural model.
module tb_multi_track_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cyc, back, play, stop_all, beat, solo;

  logic [1:0] cur_a, cur_c, cur_b;
  logic [3:0] pl_a, pd_a, au_a, pl_b, pd_b, au_b;
  logic [2:0] pl_c, pd_c, au_c;

  multi_track_controller #(.NUM_TRACKS(4), .QUANTISE(1)) dut_a (
    .clk(clk), .rst(rst), .cycle_sig(cyc), .cycle_back_sig(back), .play_sig(play),
    .stop_all_sig(stop_all), .beat_sig(beat), .solo_sig(solo),
    .current_track(cur_a), .tracks_playing(pl_a), .tracks_pending(pd_a), .tracks_audible(au_a));

  multi_track_controller #(.NUM_TRACKS(3), .QUANTISE(1)) dut_c (
    .clk(clk), .rst(rst), .cycle_sig(cyc), .cycle_back_sig(back), .play_sig(play),
    .stop_all_sig(stop_all), .beat_sig(beat), .solo_sig(solo),
    .current_track(cur_c), .tracks_playing(pl_c), .tracks_pending(pd_c), .tracks_audible(au_c));

  multi_track_controller #(.NUM_TRACKS(4), .QUANTISE(0)) dut_b (
    .clk(clk), .rst(rst), .cycle_sig(cyc), .cycle_back_sig(back), .play_sig(play),
    .stop_all_sig(stop_all), .beat_sig(beat), .solo_sig(solo),
    .current_track(cur_b), .tracks_playing(pl_b), .tracks_pending(pd_b), .tracks_audible(au_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: each track has a wanted and an actual play level; beat (or no quantising) commits want.
  int n_of [3] = '{4, 3, 4};
  bit q_of [3] = '{1'b1, 1'b1, 1'b0};
  bit on_m   [3][16];
  bit want_m [3][16];
  bit solo_m [3];
  int sel_m  [3];

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int n = n_of[k];
      int s = sel_m[k];
      if (rst) begin
        for (int i = 0; i < 16; i++) begin on_m[k][i] = 0; want_m[k][i] = 0; end
        sel_m[k] = 0;
        solo_m[k] = 0;
      end else begin
        for (int i = 0; i < n; i++) begin
          if (stop_all) begin
            on_m[k][i] = 0; want_m[k][i] = 0;
          end else begin
            if (play && i == s) want_m[k][i] = !want_m[k][i];
            if (beat || !q_of[k]) on_m[k][i] = want_m[k][i];
          end
        end
        if (cyc && !back)      sel_m[k] = (s + 1) % n;
        else if (back && !cyc) sel_m[k] = (s + n - 1) % n;
        solo_m[k] = solo;
      end
    end
  endtask

  function automatic logic [31:0] exp_play(int k);
    logic [31:0] m = '0;
    for (int i = 0; i < n_of[k]; i++) m[i] = on_m[k][i];
    return m;
  endfunction

  function automatic logic [31:0] exp_pend(int k);
    logic [31:0] m = '0;
    for (int i = 0; i < n_of[k]; i++) m[i] = on_m[k][i] ^ want_m[k][i];
    return m;
  endfunction

  function automatic logic [31:0] exp_aud(int k);
    logic [31:0] m = exp_play(k);
`ifdef MULTI_TRACK_SOLO_EN
    if (solo_m[k]) m = m & (32'd1 << sel_m[k]);
`endif
    return m;
  endfunction

  task automatic check_all(input string ph);
    logic [31:0] c, p, d, a;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin c = 32'(cur_a); p = 32'(pl_a); d = 32'(pd_a); a = 32'(au_a); end
        1:       begin c = 32'(cur_c); p = 32'(pl_c); d = 32'(pd_c); a = 32'(au_c); end
        default: begin c = 32'(cur_b); p = 32'(pl_b); d = 32'(pd_b); a = 32'(au_b); end
      endcase
      check($sformatf("%s.i%0d.sel", ph, k), c, 32'(sel_m[k]));
      check($sformatf("%s.i%0d.playing", ph, k), p, exp_play(k));
      check($sformatf("%s.i%0d.pending", ph, k), d, exp_pend(k));
      check($sformatf("%s.i%0d.audible", ph, k), a, exp_aud(k));
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic idle();
    rst = 0; cyc = 0; back = 0; play = 0; stop_all = 0; beat = 0; solo = 0;
  endtask

  task automatic do_reset(input string ph);
    idle();
    rst = 1;
    step(ph);
    rst = 0;
  endtask

  int wrap_exp [5] = '{1, 2, 0, 1, 2};

  initial begin
    idle();
    do_reset("reset");
    check("reset.cur", 32'(cur_a), 0);
    check("reset.playing", 32'(pl_a), 0);
    check("reset.pending", 32'(pd_a), 0);
    check("reset.audible", 32'(au_a), 0);

    // Selection wrap on a 3-track build
    cyc = 1;
    for (int j = 0; j < 5; j++) begin
      step("wrap");
      check($sformatf("wrap3.step%0d", j), 32'(cur_c), 32'(wrap_exp[j]));
    end
    step("wrap");
    cyc = 0; back = 1;
    step("wrapback");
    check("wrap3.back_from_0", 32'(cur_c), 2);
    back = 0;

    // Quantised start on track 1
    do_reset("q_rst");
    cyc = 1; step("q_sel");
    cyc = 0; play = 1; step("q_play");
    check("qstart.pending", 32'(pd_a), 32'b0010);
    check("qstart.playing", 32'(pl_a), 0);
    play = 0; beat = 1; step("q_beat");
    check("qstart.beat_playing", 32'(pl_a), 32'b0010);
    check("qstart.beat_pending", 32'(pd_a), 0);
    beat = 0;

    // Cancel before the beat
    do_reset("c_rst");
    cyc = 1; step("c_sel");
    cyc = 0; play = 1; step("c_play");
    step("c_cancel");
    check("cancel.pending", 32'(pd_a), 0);
    play = 0; beat = 1; step("c_beat");
    check("cancel.playing", 32'(pl_a), 0);
    beat = 0;

    // Global stop overrides play and beat
    do_reset("s_rst");
    play = 1; beat = 1; step("s_t0");
    play = 0; beat = 0; cyc = 1; step("s_c"); step("s_c");
    cyc = 0; play = 1; beat = 1; step("s_t2");
    check("stopall.pre_playing", 32'(pl_a), 32'b0101);
    play = 0; beat = 0; cyc = 1; step("s_c"); step("s_c");
    cyc = 0; stop_all = 1; play = 1; beat = 1; step("s_stop");
    check("stopall.playing", 32'(pl_a), 0);
    check("stopall.pending", 32'(pd_a), 0);
    check("stopall.cur", 32'(cur_a), 0);
    idle();

    // Immediate mode: play and cycle together act on the old selection
    do_reset("i_rst");
    play = 1; cyc = 1; step("i_play");
    check("q0.playing", 32'(pl_b), 32'b0001);
    check("q0.cur", 32'(cur_b), 1);
    idle();

    // Solo of the selected track
    do_reset("solo_rst");
    play = 1; beat = 1; step("solo_t0");
    play = 0; beat = 0; cyc = 1; step("solo_c"); step("solo_c"); step("solo_c");
    cyc = 0; play = 1; beat = 1; step("solo_t3");
    play = 0; beat = 0; solo = 1; step("solo_on");
`ifdef MULTI_TRACK_SOLO_EN
    check("solo.on", 32'(au_a), 32'b1000);
`else
    check("solo.ignored", 32'(au_a), 32'b1001);
`endif
    solo = 0; step("solo_off");
    check("solo.off", 32'(au_a), 32'b1001);

    // Random traffic
    for (int r = 0; r < 1500; r++) begin
      rst      = ($urandom_range(0, 199) == 0);
      cyc      = ($urandom_range(0, 3) == 0);
      back     = ($urandom_range(0, 4) == 0);
      play     = ($urandom_range(0, 2) == 0);
      beat     = ($urandom_range(0, 3) == 0);
      stop_all = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) solo = !solo;
      step("rand");
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
